// File: rtl/sd_pkg.sv
// Shared SD host definitions: frame geometry, CRC7 generator and the
// one-hot state encoding used by the CMD-line transmitter.
package sd_pkg;

    localparam int unsigned SD_CMD_FRAME_BITS = 48;
    localparam int unsigned SD_CMD_HDR_BITS   = 40;
    localparam logic [6:0]  SD_CRC7_POLY      = 7'h09;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_ARM  = 5'b00010,
        ST_HDR  = 5'b00100,
        ST_CRC  = 5'b01000,
        ST_END  = 5'b10000
    } sd_cmd_state_e;

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Host-side command handshake between the command register logic (master)
// and the CMD-line transmitter (slave).
interface sd_cmd_tx_if #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned ARG_W = 32
);

    logic             cmd_start;
    logic [IDX_W-1:0] cmd_index;
    logic [ARG_W-1:0] cmd_arg;
    logic             busy;
    logic             cmd_done;
    logic             cmd_abort;
    logic [6:0]       crc_out;

    modport master (
        output cmd_start, cmd_index, cmd_arg,
        input  busy, cmd_done, cmd_abort, crc_out
    );

    modport slave (
        input  cmd_start, cmd_index, cmd_arg,
        output busy, cmd_done, cmd_abort, crc_out
    );

endinterface

// File: rtl/sd_crc7_ser.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
// Shared by the command transmitter and the response receiver.
module sd_crc7_ser
    import sd_pkg::*;
#(
    parameter logic [6:0] POLY = SD_CRC7_POLY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    // Next CRC value: clear wins over a data step.
    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? POLY : 7'd0);
        end
    end

    // CRC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: serialises {start, tx, index, arg, CRC7, end}
// MSB first, changing the line one clk after each SD clock falling edge.
// A lost SD clock aborts the frame and releases the line.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned ARG_W    = 32,
    parameter logic [6:0]  CRC_POLY = SD_CRC7_POLY
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sd_clk,
    input  logic         sd_clk_stable,
    sd_cmd_tx_if.slave   bus,
    output logic         cmd_out,
    output logic         cmd_oe
);

    localparam int unsigned HDR_BITS = 2 + IDX_W + ARG_W;
    localparam int unsigned CNT_W    = $clog2(HDR_BITS + 8);
    // bit_cnt counts bits already driven; these mark the last header bit
    // having gone out and the last CRC bit having gone out.
    localparam logic [CNT_W-1:0] CNT_HDR_DONE = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0] CNT_CRC_DONE = CNT_W'(HDR_BITS + 7);

    sd_cmd_state_e       state_q, state_d;
    logic [HDR_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_out_q, cmd_out_d;
    logic                cmd_oe_q, cmd_oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic [6:0]          crc_out_q, crc_out_d;
    logic                sd_clk_q;
    logic                fall;
    logic                crc_clr;
    logic                crc_en;
    logic [6:0]          crc_val;

    assign fall = sd_clk_q & ~sd_clk;

    sd_crc7_ser #(
        .POLY (CRC_POLY)
    ) u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clr),
        .enable (crc_en),
        .din    (sr_q[HDR_BITS-1]),
        .crc    (crc_val)
    );

    // Frame sequencing; loss of a stable SD clock outranks a coincident fall.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        cmd_out_d = cmd_out_q;
        cmd_oe_d  = cmd_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        crc_out_d = crc_out_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (bus.cmd_start) begin
                if (sd_clk_stable) begin
                    sr_d    = {1'b0, 1'b1, bus.cmd_index, bus.cmd_arg};
                    cnt_d   = '0;
                    crc_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_ARM;
                end else begin
                    abort_d = 1'b1;
                end
            end
        end else if (!sd_clk_stable) begin
            cmd_oe_d  = 1'b0;
            cmd_out_d = 1'b1;
            busy_d    = 1'b0;
            abort_d   = 1'b1;
            state_d   = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_ARM: begin
                    cmd_out_d = sr_q[HDR_BITS-1];
                    cmd_oe_d  = 1'b1;
                    sr_d      = sr_q << 1;
                    crc_en    = 1'b1;
                    cnt_d     = CNT_W'(1);
                    state_d   = ST_HDR;
                end
                ST_HDR: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_HDR_DONE) begin
                        // Reuse the emptied shifter for the remaining CRC bits.
                        cmd_out_d = crc_val[6];
                        sr_d      = {crc_val[5:0], {(HDR_BITS-6){1'b0}}};
                        state_d   = ST_CRC;
                    end else begin
                        cmd_out_d = sr_q[HDR_BITS-1];
                        sr_d      = sr_q << 1;
                        crc_en    = 1'b1;
                    end
                end
                ST_CRC: begin
                    if (cnt_q == CNT_CRC_DONE) begin
                        cmd_out_d = 1'b1;
                        crc_out_d = crc_val;
                        state_d   = ST_END;
                    end else begin
                        cmd_out_d = sr_q[HDR_BITS-1];
                        sr_d      = sr_q << 1;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
                ST_END: begin
                    cmd_oe_d  = 1'b0;
                    cmd_out_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            crc_out_q <= '0;
            sd_clk_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            cmd_out_q <= cmd_out_d;
            cmd_oe_q  <= cmd_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            crc_out_q <= crc_out_d;
            sd_clk_q  <= sd_clk;
        end
    end

    assign cmd_out       = cmd_out_q;
    assign cmd_oe        = cmd_oe_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_done  = done_q;
    assign bus.cmd_abort = abort_q;
    assign bus.crc_out   = crc_out_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Scoreboard bench for sd_cmd_tx: stimulus pushes expected responses,
// a negedge monitor reassembles frames as a card would and compares.
module tb_sd_cmd_tx;

    typedef struct {
        bit          is_abort;
        logic [47:0] frame;
        logic [6:0]  crc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sd_clk = 1'b0;
    logic sd_clk_stable = 1'b1;
    logic cmd_out;
    logic cmd_oe;

    sd_cmd_tx_if #(.IDX_W(6), .ARG_W(32)) bus ();

    sd_cmd_tx #(
        .IDX_W    (6),
        .ARG_W    (32),
        .CRC_POLY (7'h09)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sd_clk        (sd_clk),
        .sd_clk_stable (sd_clk_stable),
        .bus           (bus),
        .cmd_out       (cmd_out),
        .cmd_oe        (cmd_oe)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        sb[$];
    logic [6:0]  last_crc = 7'd0;

    // SD clock generator: half period of sd_half clk cycles
    int unsigned sd_half = 1;
    bit          sd_run = 1'b1;
    int unsigned sd_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (sd_run) begin
            if (sd_cnt + 1 >= sd_half) begin
                sd_cnt = 0;
                sd_clk = ~sd_clk;
            end else begin
                sd_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [39:0] hdr);
        logic [46:0] r;
        r = {hdr, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    // Monitor: card-side sampling on SD rising edges, timing and response checks
    logic [47:0] frame_cap = '0;
    int unsigned cap_n = 0;
    logic prev_sd = 1'b0, prev2_sd = 1'b0, prev_out = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            cap_n     = 0;
            frame_cap = '0;
        end else begin
            if (!prev_sd && sd_clk && cmd_oe) begin
                frame_cap = {frame_cap[46:0], cmd_out};
                cap_n++;
            end
            if (cmd_out !== prev_out && !bus.cmd_abort)
                check("edge_timing", {62'd0, prev2_sd, prev_sd}, 64'd2);
        end
        if (bus.cmd_done || bus.cmd_abort) begin
            check("done_abort_excl", {63'd0, bus.cmd_done & bus.cmd_abort}, 64'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got done=%0b abort=%0b expected none at %0t",
                         bus.cmd_done, bus.cmd_abort, $time);
            end else begin
                e = sb.pop_front();
                check("resp_kind", {63'd0, bus.cmd_abort}, {63'd0, e.is_abort});
                check("busy_after", {63'd0, bus.busy}, 64'd0);
                check("oe_after", {63'd0, cmd_oe}, 64'd0);
                check("out_after", {63'd0, cmd_out}, 64'd1);
                check("crc_out", {57'd0, bus.crc_out}, {57'd0, e.crc});
                if (bus.cmd_done && !e.is_abort) begin
                    check("frame", {16'd0, frame_cap}, {16'd0, e.frame});
                    check("oe_periods", 64'(cap_n), 64'd48);
                end
            end
            cap_n = 0;
        end
        prev2_sd = prev_sd;
        prev_sd  = sd_clk;
        prev_out = cmd_out;
    end

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
        @(posedge clk); #1;
        bus.cmd_start = 1'b1;
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        @(posedge clk); #1;
        bus.cmd_start = 1'b0;
    endtask

    task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [47:0] frame, input logic [6:0] crc);
        exp_t e;
        e.is_abort = 1'b0;
        e.frame    = frame;
        e.crc      = crc;
        sb.push_back(e);
        last_crc = crc;
        issue(idx, arg);
    endtask

    task automatic push_random;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [39:0] hdr;
        logic [6:0]  c;
        idx = 6'($urandom_range(0, 63));
        arg = $urandom;
        hdr = {2'b01, idx, arg};
        c   = crc7_ref(hdr);
        push_frame(idx, arg, {hdr, c, 1'b1}, c);
    endtask

    task automatic push_abort;
        exp_t e;
        e.is_abort = 1'b1;
        e.frame    = '0;
        e.crc      = last_crc;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int unsigned max_cyc);
        int unsigned n = 0;
        while ((sb.size() != 0 || bus.busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= max_cyc) begin
            n_bad++;
            $display("FAIL %s: timeout after %0d cycles, %0d responses pending", name, n, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_bits(input string name, input int unsigned nbits);
        int unsigned n = 0;
        while (cap_n < nbits && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 5000) begin
            n_bad++;
            $display("FAIL %s: got %0d bits expected %0d before timeout", name, cap_n, nbits);
        end
    endtask

    initial begin
        bus.cmd_start = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg   = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", {63'd0, cmd_out}, 64'd1);
        check("rst_oe", {63'd0, cmd_oe}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.cmd_done}, 64'd0);
        check("rst_abort", {63'd0, bus.cmd_abort}, 64'd0);
        check("rst_crc", {57'd0, bus.crc_out}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // CMD0 at div=2
        sd_half = 1;
        push_frame(6'd0, 32'h0, 48'h40_0000_0000_95, 7'h4A);
        check("busy_on_start", {63'd0, bus.busy}, 64'd1);
        wait_drain("cmd0", 2000);

        // CMD8 at div=256
        sd_half = 128;
        push_frame(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, 7'h43);
        wait_drain("cmd8", 20000);

        // CMD17 with an ignored CMD55 start mid-frame
        sd_half = 2;
        push_frame(6'd17, 32'h0, 48'h51_0000_0000_55, 7'h2A);
        wait_bits("cmd17_mid", 12);
        issue(6'd55, $urandom);
        check("busy_ignored_start", {63'd0, bus.busy}, 64'd1);
        wait_drain("cmd17", 3000);

        // Start rejected while the SD clock is not stable
        @(posedge clk); #1;
        sd_clk_stable = 1'b0;
        push_abort();
        issue(6'd0, 32'h0);
        @(negedge clk);
        check("reject_busy", {63'd0, bus.busy}, 64'd0);
        check("reject_oe", {63'd0, cmd_oe}, 64'd0);
        wait_drain("reject", 100);
        @(posedge clk); #1;
        sd_clk_stable = 1'b1;

        // Clock lost at bit 20
        push_abort();
        issue(6'($urandom_range(0, 63)), $urandom);
        wait_bits("drop_bits", 20);
        @(posedge clk); #1;
        sd_clk_stable = 1'b0;
        sd_run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_abort", {63'd0, bus.cmd_abort}, 64'd1);
        check("drop_oe", {63'd0, cmd_oe}, 64'd0);
        check("drop_out", {63'd0, cmd_out}, 64'd1);
        check("drop_busy", {63'd0, bus.busy}, 64'd0);
        wait_drain("drop", 100);
        repeat (5) @(posedge clk);
        #1;
        sd_run = 1'b1;
        sd_clk_stable = 1'b1;
        repeat (4) @(posedge clk);
        push_frame(6'd0, 32'h0, 48'h40_0000_0000_95, 7'h4A);
        wait_drain("cmd0_restart", 3000);

        // Random commands at assorted SD clock dividers
        for (int i = 0; i < 8; i++) begin
            sd_half = $urandom_range(1, 4);
            push_random();
            wait_drain("random", 5000);
        end

        // Reset mid-frame at bit 30: no pulse expected, outputs return to reset values
        sd_half = 2;
        issue(6'($urandom_range(0, 63)), $urandom);
        wait_bits("reset_bits", 30);
        @(posedge clk); #1;
        reset = 1'b1;
        last_crc = 7'd0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out", {63'd0, cmd_out}, 64'd1);
        check("mid_rst_oe", {63'd0, cmd_oe}, 64'd0);
        check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("mid_rst_done", {63'd0, bus.cmd_done}, 64'd0);
        check("mid_rst_abort", {63'd0, bus.cmd_abort}, 64'd0);
        check("mid_rst_crc", {57'd0, bus.crc_out}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        push_random();
        wait_drain("after_reset", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
